// File: rtl/bcd_pkg.sv
// Shared constants for the BCD scan controller: widths, FSM state codes and
// active-low 7-segment patterns ({g,f,e,d,c,b,a}, 0 = segment lit).
package bcd_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned IN_W       = 16;
  localparam int unsigned BCD_W      = 20;
  localparam int unsigned SHR_W      = BCD_W + IN_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_scan_ctrl_if.sv
// Value-source / display bundle of the BCD scan controller.
//   in_valid/in_ready/in_value : input handshake (master drives valid/value)
//   bcd_out/bcd_valid/busy     : conversion result and status
//   an/seg                     : active-low digit enables and segments
interface bcd_scan_ctrl_if;
  import bcd_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_value;
  logic [BCD_W-1:0]      bcd_out;
  logic                  bcd_valid;
  logic                  busy;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;

  modport master (
    output in_valid, in_value,
    input  in_ready, bcd_out, bcd_valid, busy, an, seg
  );

  modport slave (
    input  in_valid, in_value,
    output in_ready, bcd_out, bcd_valid, busy, an, seg
  );

endinterface

// File: rtl/bcd_seg_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
//   digit_i : 4-bit digit, 10..15 decode to blank
//   blank_i : force all segments off
//   seg_o   : {g,f,e,d,c,b,a}, active-low
module bcd_seg_decode
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      unique case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Sequential binary-to-BCD converter (double dabble, one iteration per clock)
// with a free-running 5-digit common-anode scan driver.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of bcd_scan_ctrl_if (handshake in, result/status/display out)
module bcd_scan_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 50000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  bcd_scan_ctrl_if.slave  bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]       state_q, state_d;
  logic [SHR_W-1:0] shreg_q, shreg_d;
  logic [3:0]       iter_q, iter_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;

  logic [SHR_W-1:0] corrected;
  logic             presc_wrap;
  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       seg_w;

  // Conversion FSM and datapath
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    iter_d    = iter_q;
    bcd_d     = bcd_q;
    corrected = {add3_nibbles(shreg_q[SHR_W-1 -: BCD_W]), shreg_q[IN_W-1:0]};
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          shreg_d = {{BCD_W{1'b0}}, bus.in_value};
          iter_d  = 4'd0;
          state_d = StShift;
        end
      end
      StShift: begin
        shreg_d = {corrected[SHR_W-2:0], 1'b0};
        iter_d  = iter_q + 4'd1;
        if (iter_q == 4'd15) begin
          // Publish only the finished result so bcd_out never shows partial sums.
          bcd_d   = corrected[SHR_W-2 -: BCD_W];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Scan prescaler and digit index, independent of the FSM
  always_comb begin
    presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    if (presc_wrap) idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      iter_q  <= '0;
      bcd_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  // Digit select; a digit is blank when it and every more-significant digit are zero.
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        nibble = bcd_q[4*k +: 4];
        blank  = BLANK_LEADING && (k != 0) && ((bcd_q >> (4*k)) == '0);
      end
    end
  end

  bcd_seg_decode u_seg_decode (
    .digit_i (nibble),
    .blank_i (blank),
    .seg_o   (seg_w)
  );

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.bcd_valid = (state_q == StDone);
  assign bus.bcd_out   = bcd_q;
  assign bus.an        = ~(NUM_DIGITS'(1) << idx_q);
  assign bus.seg       = seg_w;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl: scoreboard of expected BCD results, latency and
// handshake checks, digit scan order and leading-zero blanking (two DUT variants).
module tb_bcd_scan_ctrl;

  logic clk;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [19:0] exp_q[$];

  bcd_scan_ctrl_if bus   ();
  bcd_scan_ctrl_if bus_b ();

  assign bus_b.in_valid = bus.in_valid;
  assign bus_b.in_value = bus.in_value;

  bcd_scan_ctrl #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bcd_scan_ctrl #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int k, input bit blank_en);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (blank_en && k > 0 && v < p) return 7'h7F;
    return seg_of((v / p) % 10);
  endfunction

  // Presents v, waits for acceptance, then follows the conversion to its DONE cycle.
  task automatic do_conv(input int v, input bit hold, output int n_wait);
    int lat;
    bit ready_low;
    logic [19:0] e;
    bus.in_valid = 1'b1;
    bus.in_value = 16'(v);
    n_wait = 0;
    while (!bus.in_ready && n_wait < 100) begin
      tick();
      n_wait++;
    end
    chk("accept_ready", {35'd0, bus.in_ready}, 36'd1);
    exp_q.push_back(to_bcd(v));
    tick();
    if (!hold) begin
      bus.in_valid = 1'b0;
      bus.in_value = ~16'(v);
    end
    lat = 1;
    ready_low = 1'b1;
    while (!bus.bcd_valid && lat < 40) begin
      if (bus.in_ready) ready_low = 1'b0;
      tick();
      lat++;
    end
    chk("latency", 36'(lat), 36'd17);
    chk("ready_low_shift", {35'd0, ready_low}, 36'd1);
    chk("ready_low_done", {35'd0, bus.in_ready}, 36'd0);
    chk("busy_done", {35'd0, bus.busy}, 36'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 36'd1, 36'd0);
    end else begin
      e = exp_q.pop_front();
      chk("bcd_out", {16'd0, bus.bcd_out}, {16'd0, e});
      chk("bcd_out_b", {16'd0, bus_b.bcd_out}, {16'd0, e});
    end
  endtask

  // Cycle after DONE: pulse gone, result held, ready again.
  task automatic post_check(input int v);
    tick();
    chk("valid_pulse_end", {35'd0, bus.bcd_valid}, 36'd0);
    chk("bcd_out_hold", {16'd0, bus.bcd_out}, {16'd0, to_bcd(v)});
    chk("ready_idle", {35'd0, bus.in_ready}, 36'd1);
    chk("busy_idle", {35'd0, bus.busy}, 36'd0);
  endtask

  task automatic check_display(input int v);
    logic [4:0] tgt;
    int n;
    for (int k = 0; k < 5; k++) begin
      tgt = ~(5'd1 << k);
      n = 0;
      while (bus.an !== tgt && n < 40) begin
        tick();
        n++;
      end
      chk("digit_found", {31'd0, bus.an}, {31'd0, tgt});
      chk("seg_blank", {29'd0, bus.seg}, {29'd0, exp_seg(v, k, 1'b1)});
      chk("seg_noblank", {29'd0, bus_b.seg}, {29'd0, exp_seg(v, k, 1'b0)});
    end
  endtask

  initial begin
    int n_wait;
    int n;
    bit seen;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_value = 16'd0;
    tick();
    tick();

    chk("rst_in_ready", {35'd0, bus.in_ready}, 36'd1);
    chk("rst_busy", {35'd0, bus.busy}, 36'd0);
    chk("rst_bcd_valid", {35'd0, bus.bcd_valid}, 36'd0);
    chk("rst_bcd_out", {16'd0, bus.bcd_out}, 36'd0);
    chk("rst_an", {31'd0, bus.an}, {31'd0, 5'b11110});
    chk("rst_seg", {29'd0, bus.seg}, {29'd0, 7'b1000000});
    reset = 1'b0;

    // Scan order with SCAN_DIV=4, including the wrap back to digit0.
    for (int c = 0; c < 24; c++) begin
      chk("scan_an", {31'd0, bus.an}, {31'd0, ~(5'd1 << ((c / 4) % 5))});
      tick();
    end

    do_conv(0, 1'b0, n_wait);
    post_check(0);
    check_display(0);

    do_conv(65535, 1'b0, n_wait);
    post_check(65535);
    check_display(65535);

    do_conv(1234, 1'b0, n_wait);
    post_check(1234);
    check_display(1234);

    // Back-to-back with in_valid held: second accept the cycle after bcd_valid.
    do_conv(9, 1'b1, n_wait);
    do_conv(10, 1'b1, n_wait);
    chk("b2b_accept_wait", 36'(n_wait), 36'd1);
    bus.in_valid = 1'b0;
    post_check(10);

    // Reset during the 8th SHIFT cycle aborts the conversion.
    bus.in_valid = 1'b1;
    bus.in_value = 16'd4321;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
    repeat (7) tick();
    chk("mid_busy", {35'd0, bus.busy}, 36'd1);
    reset = 1'b1;
    tick();
    chk("abort_in_ready", {35'd0, bus.in_ready}, 36'd1);
    chk("abort_busy", {35'd0, bus.busy}, 36'd0);
    chk("abort_bcd_out", {16'd0, bus.bcd_out}, 36'd0);
    chk("abort_an", {31'd0, bus.an}, {31'd0, 5'b11110});
    chk("abort_seg", {29'd0, bus.seg}, {29'd0, 7'b1000000});
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.bcd_valid) seen = 1'b1;
      tick();
    end
    chk("abort_no_valid", {35'd0, seen}, 36'd0);
    chk("abort_bcd_out_hold", {16'd0, bus.bcd_out}, 36'd0);
    chk("abort_ready_after", {35'd0, bus.in_ready}, 36'd1);
    chk("scoreboard_drained", 36'(exp_q.size()), 36'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
